// File: rtl/rv32ima_mem_arbiter.sv
// Two-master (fetch / data) arbiter in front of a single-port synchronous memory.
// Round-robin under contention, with a D-port lock held across atomic read-modify-write sequences.
module rv32ima_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic [DW/8-1:0] d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic            d_lock,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  state_t state_reg, state_next;
  owner_t owner_reg, owner_next;
  logic   last_d_reg, last_d_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_OPEN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Lock follows d_lock of every granted D transaction, in either state.
  always_comb begin
    state_next = state_reg;
    if (d_gnt) begin
      state_next = d_lock ? ST_LOCKED : ST_OPEN;
    end
  end

  // Grants are gated by reset so nothing reaches memory while it is asserted.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (state_reg == ST_LOCKED) begin
        d_gnt = d_req;
      end else if (i_req && d_req) begin
        d_gnt = !last_d_reg;
        i_gnt = last_d_reg;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  always_comb begin
    last_d_next = last_d_reg;
    owner_next  = OWN_NONE;
    if (d_gnt) begin
      last_d_next = 1'b1;
      owner_next  = OWN_D;
    end else if (i_gnt) begin
      last_d_next = 1'b0;
      owner_next  = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_reg <= 1'b0;
      owner_reg  <= OWN_NONE;
    end else begin
      last_d_reg <= last_d_next;
      owner_reg  <= owner_next;
    end
  end

  assign mem_en   = i_gnt | d_gnt;
  assign mem_addr = d_gnt ? d_addr : (i_gnt ? i_addr : '0);

  // Write lanes are only ever driven by the D port.
  genvar gi;
  generate
    for (gi = 0; gi < BW; gi++) begin : g_lane
      assign mem_we[gi]             = d_gnt & d_we[gi];
      assign mem_wdata[gi*8 +: 8]   = d_gnt ? d_wdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign i_rvalid = (owner_reg == OWN_I);
  assign d_rvalid = (owner_reg == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_rv32ima_mem_arbiter.sv
// Bench for rv32ima_mem_arbiter: behavioural memory, directed test-plan steps, then random traffic
// checked against a transaction-level model (lock flag, last winner, pending response, shadow memory).
module tb_rv32ima_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_lock;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  rv32ima_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    logic [7:0] kb;
    kb = k[7:0];
    if (k == 4) return 32'h0000_0013;
    return {kb ^ 8'h5A, 8'hC3, kb, 8'h3C};
  endfunction

  // Environment memory: one-cycle read latency, byte-strobed writes.
  logic [31:0] env_mem [256];
  logic        load_en;
  always @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < 256; k++) env_mem[k] <= init_word(k);
    end else if (mem_en) begin
      mem_rdata <= env_mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) env_mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // Reference model state
  logic [31:0] shadow [256];
  bit          m_locked;
  bit          m_last_d;
  int          p_who;      // 0 none, 1 I, 2 D
  bit          p_wr;
  logic [31:0] p_data;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst_v, input bit ireq, input logic [31:0] iaddr,
                      input bit dreq, input logic [3:0] dwe, input logic [31:0] daddr,
                      input logic [31:0] dwdata, input bit dlock);
    bit eg_i, eg_d;
    @(negedge clk);
    rst = rst_v; i_req = ireq; i_addr = iaddr;
    d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata; d_lock = dlock;
    #1;
    if (!rst_v) begin
      m_locked = 1'b0; m_last_d = 1'b0; p_who = 0;
    end
    chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, p_who == 1});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, p_who == 2});
    if (p_who == 1) chk("i_rdata", i_rdata, p_data);
    if (p_who == 2 && !p_wr) chk("d_rdata", d_rdata, p_data);

    eg_i = 1'b0; eg_d = 1'b0;
    if (rst_v) begin
      if (m_locked) eg_d = dreq;
      else if (ireq && dreq) begin eg_d = !m_last_d; eg_i = m_last_d; end
      else begin eg_i = ireq; eg_d = dreq; end
    end
    chk("i_gnt", {31'd0, i_gnt}, {31'd0, eg_i});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, eg_d});
    chk("mem_en", {31'd0, mem_en}, {31'd0, eg_i | eg_d});
    chk("mem_addr", mem_addr, eg_d ? daddr : (eg_i ? iaddr : 32'd0));
    chk("mem_we", {28'd0, mem_we}, eg_d ? {28'd0, dwe} : 32'd0);
    chk("mem_wdata", mem_wdata, eg_d ? dwdata : 32'd0);

    p_who = 0;
    if (eg_i) begin
      p_who = 1; p_wr = 1'b0; p_data = shadow[iaddr[9:2]]; m_last_d = 1'b0;
    end
    if (eg_d) begin
      p_who = 2; p_wr = (dwe != 4'd0); p_data = shadow[daddr[9:2]];
      for (int b = 0; b < 4; b++)
        if (dwe[b]) shadow[daddr[9:2]][b*8 +: 8] = dwdata[b*8 +: 8];
      m_last_d = 1'b1; m_locked = dlock;
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rw;
    logic [3:0]  rwe;
    rst = 1'b0; load_en = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_lock = 0;
    for (int k = 0; k < 256; k++) shadow[k] = init_word(k);
    m_locked = 0; m_last_d = 0; p_who = 0; p_wr = 0; p_data = 0;
    @(negedge clk);
    load_en = 1'b0;

    // Reset held with both requesting, then release: D first, then I
    step(0, 1, 32'h40, 1, 4'h0, 32'h80, 32'h0, 0);
    step(0, 1, 32'h40, 1, 4'h0, 32'h80, 32'h0, 0);
    step(1, 1, 32'h40, 1, 4'h0, 32'h80, 32'h0, 0);
    step(1, 1, 32'h40, 0, 4'h0, 32'h0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Single fetch from 0x10
    step(1, 1, 32'h10, 0, 4'h0, 32'h0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Contention for 8 cycles
    for (int c = 0; c < 8; c++) begin
      ra = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      rb = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      step(1, 1, ra, 1, 4'h0, rb, 32'h0, 0);
    end
    step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Partial write then read back
    step(1, 0, 32'h0, 1, 4'b0011, 32'h100, 32'hAABBCCDD, 0);
    step(1, 0, 32'h0, 1, 4'b0000, 32'h100, 32'h0, 0);
    step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Atomic lock with I waiting throughout
    step(1, 1, 32'h20, 1, 4'h0, 32'h200, 32'h0, 1);
    step(1, 1, 32'h20, 0, 4'h0, 32'h0, 32'h0, 0);
    step(1, 1, 32'h20, 1, 4'hF, 32'h200, 32'h12345678, 0);
    step(1, 1, 32'h20, 0, 4'h0, 32'h0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Reset pulse while locked with a response in flight
    step(1, 0, 32'h0, 1, 4'h0, 32'h204, 32'h0, 1);
    step(0, 1, 32'h24, 0, 4'h0, 32'h0, 32'h0, 0);
    step(1, 1, 32'h24, 0, 4'h0, 32'h0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      ra  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      rb  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      rw  = $urandom;
      rwe = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), ra,
           ($urandom_range(0, 2) != 0), rwe, rb, rw, ($urandom_range(0, 3) == 0));
    end
    step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
